ysyx_220066_ex_mdu: RTL and testbench

YSYX_220066_EX_MDU -- requirements
Module: ysyx_220066_ex_mdu

---
 rtl/ysyx_220066_ex_mdu_if.sv | 30 +++
 rtl/ysyx_220066_ex_mdu.sv | 166 ++++++++++++++++
 tb/tb_ysyx_220066_ex_mdu.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220066_ex_mdu_if.sv
// rtl/ysyx_220066_ex_mdu_if.sv - issue/result bundle between the execute stage and the MDU
interface ysyx_220066_ex_mdu_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [4:0]      rd_in;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd;
  logic [XLEN-1:0] pc;
  logic            busy;

  modport master (
    output in_valid, flush, op, word, src1, src2, rd_in, pc_in, out_ready,
    input  in_ready, out_valid, result, rd, pc, busy
  );

  modport slave (
    input  in_valid, flush, op, word, src1, src2, rd_in, pc_in, out_ready,
    output in_ready, out_valid, result, rd, pc, busy
  );
endinterface

// File: rtl/ysyx_220066_ex_mdu.sv
// rtl/ysyx_220066_ex_mdu.sv - iterative radix-2 multiply/divide unit (RV M extension)
module ysyx_220066_ex_mdu #(
  parameter int XLEN = 64
) (
  input logic               clk,
  input logic               rst,
  ysyx_220066_ex_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q;     // multiplier / dividend-then-quotient
  logic [XLEN-1:0] opnd_q;   // multiplicand / divisor magnitude
  logic [2:0]      op_q;
  logic            word_q;
  logic            neg_q;    // result must be negated in the last step
  logic            out_valid_q;
  logic            busy_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = XLEN'($signed(v));
  endfunction

  // Decode of the presented operation and operand magnitudes
  logic            word_eff, is_div, s1_signed, s2_signed, sb1, sb2, neg1, neg2;
  logic            div_zero, div_ovf, res_neg;
  logic [2:0]      op_eff;
  logic [XLEN-1:0] mask, a_m, b_m, mag1, mag2, min_w, dividend_res, quick_res;
  always_comb begin
    word_eff  = (XLEN == 64) & bus.word;
    // High-half multiplies collapse to MULW in word mode
    op_eff    = (word_eff && !bus.op[2] && (bus.op[1:0] != 2'd0)) ? 3'd0 : bus.op;
    is_div    = op_eff[2];
    s1_signed = is_div ? !op_eff[0] : (op_eff != 3'd3);
    s2_signed = is_div ? !op_eff[0] : !op_eff[1];
    mask      = word_eff ? XLEN'(32'hFFFF_FFFF) : '1;
    a_m       = bus.src1 & mask;
    b_m       = bus.src2 & mask;
    sb1       = word_eff ? bus.src1[31] : bus.src1[XLEN-1];
    sb2       = word_eff ? bus.src2[31] : bus.src2[XLEN-1];
    neg1      = s1_signed & sb1;
    neg2      = s2_signed & sb2;
    mag1      = (neg1 ? (~a_m + XLEN'(1)) : a_m) & mask;
    mag2      = (neg2 ? (~b_m + XLEN'(1)) : b_m) & mask;
    min_w     = word_eff ? XLEN'(32'h8000_0000) : (XLEN'(1) << (XLEN - 1));
    div_zero  = is_div && (b_m == '0);
    div_ovf   = is_div && !op_eff[0] && (a_m == min_w) && (b_m == mask);
    // Remainder follows the dividend; product and quotient use sign1 ^ sign2
    res_neg   = (is_div && op_eff[1]) ? neg1 : (neg1 ^ neg2);
    dividend_res = word_eff ? sext32(bus.src1[31:0]) : bus.src1;
    quick_res = '1;
    if (div_zero) quick_res = op_eff[1] ? dividend_res : '1;
    else if (div_ovf) quick_res = op_eff[1] ? '0 : dividend_res;
  end

  // One radix-2 iteration of shift-add multiply or restoring divide
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] hi_d, lo_d;
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_ge   = !div_diff[XLEN];
    if (op_q[2]) begin
      hi_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Signed result built from the values the last iteration produces
  logic [2*XLEN-1:0] prod, prod_s;
  logic [31:0]       wlo, wlo_s;
  logic [XLEN-1:0]   dv, dv_s, fin_res;
  always_comb begin
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
    // In word mode the 32-bit low product sits at the top of lo
    wlo    = lo_d[XLEN-1 -: 32];
    wlo_s  = neg_q ? (~wlo + 32'd1) : wlo;
    dv     = op_q[1] ? hi_d : lo_d;
    dv_s   = neg_q ? (~dv + XLEN'(1)) : dv;
    if (op_q[2])       fin_res = word_q ? sext32(dv_s[31:0]) : dv_s;
    else if (word_q)   fin_res = sext32(wlo_s);
    else if (op_q == 3'd0) fin_res = prod_s[XLEN-1:0];
    else               fin_res = prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM with registered outputs; flush beats everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          op_q   <= op_eff;
          word_q <= word_eff;
          neg_q  <= res_neg;
          rd_q   <= bus.rd_in;
          pc_q   <= bus.pc_in;
          busy_q <= 1'b1;
          if (div_zero || div_ovf) begin
            result_q    <= quick_res;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q   <= word_eff ? CW'(31) : CW'(XLEN - 1);
            hi_q    <= '0;
            lo_q    <= is_div ? (word_eff ? (mag1 << (XLEN - 32)) : mag1) : mag2;
            opnd_q  <= is_div ? mag2 : mag1;
            state_q <= CALC;
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            result_q    <= fin_res;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !bus.flush;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.rd        = rd_q;
  assign bus.pc        = pc_q;
endmodule

// File: tb/tb_ysyx_220066_ex_mdu.sv
// tb/tb_ysyx_220066_ex_mdu.sv - directed self-checking bench for ysyx_220066_ex_mdu
module tb_ysyx_220066_ex_mdu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ysyx_220066_ex_mdu_if #(.XLEN(64)) bus ();
  ysyx_220066_ex_mdu #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] r, input logic [63:0] p);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.word = w;
    bus.src1 = a; bus.src2 = b; bus.rd_in = r; bus.pc_in = p;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // lat = rising edges after the accept edge until out_valid is seen
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain;
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #3;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'd0 ||
        bus.rd !== 5'd0 || bus.pc !== 64'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: ov=%b busy=%b res=%h rd=%0d pc=%h rdy=%b, expected 0 0 0 0 0 1",
               bus.out_valid, bus.busy, bus.result, bus.rd, bus.pc, bus.in_ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul;
    logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [63:0] as  [4] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2};
    logic [63:0] bs  [4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
                             64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] ex  [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 1'b0, as[i], bs[i], 5'(i + 1), 64'h1000 + 64'(i));
      wait_done(lat);
      n_checks++;
      if (lat !== 64 || bus.result !== ex[i] || bus.rd !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL mul[%0d]: res=%h lat=%0d rd=%0d, expected res=%h lat=64 rd=%0d",
                 i, bus.result, lat, bus.rd, ex[i], i + 1);
      end
      drain;
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [5] = '{3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [63:0] as  [5] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFEC, 64'd20, 64'd100,
                             64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] bs  [5] = '{64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'd10};
    logic [63:0] ex  [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 64'd2, 64'd14,
                             64'd5};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], 1'b0, as[i], bs[i], 5'd3, 64'h2000);
      wait_done(lat);
      n_checks++;
      if (lat !== 64 || bus.result !== ex[i]) begin
        n_fail++;
        $display("FAIL div[%0d]: res=%h lat=%0d, expected res=%h lat=64",
                 i, bus.result, lat, ex[i]);
      end
      drain;
    end
  endtask

  task automatic test_word;
    logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd5, 3'd7, 3'd4};
    logic [63:0] as  [5] = '{64'hDEAD_0000_7FFF_FFFF, 64'd3, 64'h0000_0000_FFFF_FFFF,
                             64'h5555_0000_8000_0001, 64'h0000_0000_FFFF_FFEC};
    logic [63:0] bs  [5] = '{64'd2, 64'd5, 64'd1, 64'd16, 64'hABCD_0000_0000_0003};
    logic [63:0] ex  [5] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                             64'hFFFF_FFFF_FFFF_FFFA};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], 1'b1, as[i], bs[i], 5'd4, 64'h3000);
      wait_done(lat);
      n_checks++;
      if (lat !== 32 || bus.result !== ex[i]) begin
        n_fail++;
        $display("FAIL word[%0d]: res=%h lat=%0d, expected res=%h lat=32",
                 i, bus.result, lat, ex[i]);
      end
      drain;
    end
  endtask

  // Divide-by-zero and signed overflow complete in the cycle after accept
  task automatic test_div_special;
    logic [2:0]  ops [6] = '{3'd5, 3'd6, 3'd4, 3'd4, 3'd6, 3'd6};
    logic        ws  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] as  [6] = '{64'd1234, 64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000,
                             64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000,
                             64'h1234_5678_FFFF_FFF9};
    logic [63:0] bs  [6] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000};
    logic [63:0] ex  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB,
                             64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 64'd0,
                             64'hFFFF_FFFF_FFFF_FFF9};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], ws[i], as[i], bs[i], 5'd6, 64'h4000);
      wait_done(lat);
      n_checks++;
      if (lat !== 0 || bus.result !== ex[i]) begin
        n_fail++;
        $display("FAIL divspec[%0d]: res=%h lat=%0d, expected res=%h lat=0",
                 i, bus.result, lat, ex[i]);
      end
      drain;
    end
  endtask

  task automatic test_hold;
    int lat;
    issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd9, 64'h8000_1000);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 64'd14 || bus.rd !== 5'd9 ||
          bus.pc !== 64'h8000_1000 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: ov=%b res=%h rd=%0d pc=%h rdy=%b, expected 1 e 9 80001000 0",
                 i, bus.out_valid, bus.result, bus.rd, bus.pc, bus.in_ready);
      end
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: ov=%b busy=%b rdy=%b, expected 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_flush;
    int lat;
    issue(3'd0, 1'b0, 64'd100, 64'd100, 5'd1, 64'h5000);
    repeat (10) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0; #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: ov=%b busy=%b rdy=%b, expected 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    issue(3'd0, 1'b0, 64'd3, 64'd4, 5'd2, 64'h5004);
    wait_done(lat);
    n_checks++;
    if (lat !== 64 || bus.result !== 64'd12) begin
      n_fail++;
      $display("FAIL flush_next: res=%h lat=%0d, expected res=c lat=64", bus.result, lat);
    end
    drain;
  endtask

  task automatic test_back_to_back;
    int acc [2];
    int na = 0;
    int lat;
    @(negedge clk);
    bus.op = 3'd0; bus.word = 1'b1; bus.src1 = 64'd5; bus.src2 = 64'd6;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 120 && na < 2; i++) begin
      if (i != 0) @(negedge clk);
      if (bus.in_ready && bus.out_valid) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_overlap[%0d]: in_ready and out_valid both 1", i);
      end
      if (bus.out_valid) begin
        n_checks++;
        if (bus.result !== 64'd30) begin
          n_fail++;
          $display("FAIL b2b_first: res=%h, expected 1e", bus.result);
        end
      end
      if (bus.in_ready) begin acc[na] = i; na++; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_checks++;
    if (na !== 2 || acc[1] - acc[0] !== 34) begin
      n_fail++;
      $display("FAIL b2b_spacing: accepts=%0d spacing=%0d, expected 2 and 34",
               na, acc[1] - acc[0]);
    end
    wait_done(lat);
    n_checks++;
    if (lat !== 32 || bus.result !== 64'd30) begin
      n_fail++;
      $display("FAIL b2b_second: res=%h lat=%0d, expected res=1e lat=32", bus.result, lat);
    end
    drain;
  endtask

  task automatic test_async_reset;
    int lat;
    issue(3'd4, 1'b0, 64'd8, 64'd2, 5'd17, 64'h6000);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'd0 ||
        bus.rd !== 5'd0 || bus.pc !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: ov=%b busy=%b res=%h rd=%0d pc=%h, expected all 0",
               bus.out_valid, bus.busy, bus.result, bus.rd, bus.pc);
    end
    @(negedge clk); rst = 1'b0;
    issue(3'd4, 1'b0, 64'd8, 64'd2, 5'd18, 64'h6004);
    wait_done(lat);
    n_checks++;
    if (lat !== 64 || bus.result !== 64'd4 || bus.rd !== 5'd18 || bus.pc !== 64'h6004) begin
      n_fail++;
      $display("FAIL after_reset: res=%h lat=%0d rd=%0d pc=%h, expected 4 64 18 6004",
               bus.result, lat, bus.rd, bus.pc);
    end
    drain;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.word = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.rd_in = '0; bus.pc_in = '0; bus.out_ready = 1'b0;
    test_reset;
    test_mul;
    test_div;
    test_word;
    test_div_special;
    test_hold;
    test_flush;
    test_back_to_back;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
